hp_au_cmd_issuer: RTL and testbench

Sequential command front-end that drives the combinational HP-AU. It accepts operation commands over a valid/ready channel and presents operands and `sel` to the AU. It captures the AU result after one settle cycle and returns it over a valid/ready response channel. It keeps an accumulator so consecutive commands can chain on the previous result.

---
 rtl/hp_au_cmd_issuer.sv | 109 ++++++++++
 tb/tb_hp_au_cmd_issuer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_au_cmd_issuer.sv
// Command front-end for the combinational HP-AU: issues one operation, waits a settle
// cycle, then holds the captured result on a valid/ready response channel.
module hp_au_cmd_issuer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [2:0]       au_sel,
    input  logic [WIDTH-1:0] au_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_sel,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] au_a_q, au_a_d;
    logic [WIDTH-1:0] au_b_q, au_b_d;
    logic [2:0]       au_sel_q, au_sel_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_sel_q, rsp_sel_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            au_a_q     <= '0;
            au_b_q     <= '0;
            au_sel_q   <= '0;
            rsp_data_q <= '0;
            rsp_sel_q  <= '0;
            acc_q      <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            au_a_q     <= au_a_d;
            au_b_q     <= au_b_d;
            au_sel_q   <= au_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_sel_q  <= rsp_sel_d;
            acc_q      <= acc_d;
            op_count_q <= op_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        au_a_d     = au_a_q;
        au_b_d     = au_b_q;
        au_sel_d   = au_sel_q;
        rsp_data_d = rsp_data_q;
        rsp_sel_d  = rsp_sel_q;
        acc_d      = acc_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    au_a_d   = cmd_chain ? acc_q : cmd_a;
                    au_b_d   = cmd_b;
                    au_sel_d = cmd_sel;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // The AU has had a full cycle to settle on the registered operands.
                rsp_data_d = au_result;
                rsp_sel_d  = au_sel_q;
                acc_d      = au_result;
                op_count_d = op_count_q + CNT_W'(1);
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign au_a      = au_a_q;
    assign au_b      = au_b_q;
    assign au_sel    = au_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_sel   = rsp_sel_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_hp_au_cmd_issuer.sv
// Self-checking bench for hp_au_cmd_issuer: directed vector table, hand-written
// backpressure/reset sequences, and random traffic against a transaction-level model.
module tb_hp_au_cmd_issuer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_sel;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_chain;
    logic [WIDTH-1:0] au_a;
    logic [WIDTH-1:0] au_b;
    logic [2:0]       au_sel;
    logic [WIDTH-1:0] au_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_sel;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_acc;
    int               m_cnt;

    typedef struct {
        logic [2:0]       sel;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             chain;
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_data;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    hp_au_cmd_issuer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .au_a(au_a), .au_b(au_b), .au_sel(au_sel), .au_result(au_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_sel(rsp_sel), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Stand-in AU: any pure function of (a, b, sel) exercises the issuer.
    function automatic logic [WIDTH-1:0] au_func(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0] sel);
        int s;
        case (sel)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: begin
                s = int'(a) + int'(b);
                if (s > 9) s = s + 6;
                return WIDTH'(s);
            end
            3'd3: return a + b;
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return a << 1;
        endcase
    endfunction

    always_comb au_result = au_func(au_a, au_b, au_sel);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout actual=%b expected=1", cmd_ready);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_acc = '0;
        m_cnt = 0;
    endtask

    // Full transaction: accept, check latency, hold response for 'hold' cycles, drain.
    task automatic applyStimulus(input logic [2:0] sel, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic chain,
                                 input logic [WIDTH-1:0] exp_a, input logic [WIDTH-1:0] exp_data,
                                 input logic [CNT_W-1:0] exp_cnt, input int hold);
        waitIdle();
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("busy_exec", 32'(busy), 32'd1);
        checkOutput("rsp_valid_exec", 32'(rsp_valid), 32'd0);
        checkOutput("au_a", 32'(au_a), 32'(exp_a));
        checkOutput("au_b", 32'(au_b), 32'(b));
        checkOutput("au_sel", 32'(au_sel), 32'(sel));
        @(negedge clk);
        checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
        checkOutput("rsp_sel", 32'(rsp_sel), 32'(sel));
        checkOutput("op_count", 32'(op_count), 32'(exp_cnt));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rsp_data", 32'(rsp_data), 32'(exp_data));
            checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_drained", 32'(rsp_valid), 32'd0);
        checkOutput("cmd_ready_after", 32'(cmd_ready), 32'd1);
        m_acc = exp_data;
        m_cnt = int'(exp_cnt);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [CNT_W-1:0] wrap_seq [5];
        logic [2:0]       r_sel;
        logic [WIDTH-1:0] r_a, r_b, r_exp_a, r_exp_d;
        logic             r_chain;

        rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_sel = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0;

        vecs[0] = '{3'd0, 4'h3, 4'h5, 1'b0, 4'h3, 4'h8, 2'd1};
        vecs[1] = '{3'd1, 4'h2, 4'h5, 1'b0, 4'h2, 4'hD, 2'd2};
        vecs[2] = '{3'd4, 4'h0, 4'h6, 1'b1, 4'hD, 4'h4, 2'd3};
        vecs[3] = '{3'd5, 4'hA, 4'h5, 1'b0, 4'hA, 4'hF, 2'd0};
        vecs[4] = '{3'd6, 4'h1, 4'hF, 1'b1, 4'hF, 4'h0, 2'd1};
        vecs[5] = '{3'd2, 4'h5, 4'h8, 1'b0, 4'h5, 4'h3, 2'd2};
        vecs[6] = '{3'd7, 4'h9, 4'h2, 1'b1, 4'h3, 4'h6, 2'd3};

        doReset();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_op_count", 32'(op_count), 32'd0);
        checkOutput("rst_au_a", 32'(au_a), 32'd0);
        checkOutput("rst_au_b", 32'(au_b), 32'd0);
        checkOutput("rst_au_sel", 32'(au_sel), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_rsp_sel", 32'(rsp_sel), 32'd0);

        for (int i = 0; i < 7; i++)
            applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].chain,
                          vecs[i].exp_a, vecs[i].exp_data, vecs[i].exp_cnt, i % 3);

        // Backpressure with a second command queued behind the pending response.
        waitIdle();
        cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_a = 4'h1; cmd_b = 4'h1; cmd_chain = 1'b0;
        @(negedge clk);
        cmd_sel = 3'd6; cmd_a = 4'h7; cmd_b = 4'hF; cmd_chain = 1'b1;
        @(negedge clk);
        checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_rsp_data", 32'(rsp_data), 32'h2);
        checkOutput("bp_op_count", 32'(op_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_hold_data", 32'(rsp_data), 32'h2);
            checkOutput("bp_hold_sel", 32'(rsp_sel), 32'd0);
            checkOutput("bp_hold_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("bp_release_idle", 32'(cmd_ready), 32'd1);
        checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("bp_queued_busy", 32'(busy), 32'd1);
        checkOutput("bp_queued_au_a", 32'(au_a), 32'h2);
        checkOutput("bp_queued_au_sel", 32'(au_sel), 32'd6);
        @(negedge clk);
        checkOutput("bp_queued_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_queued_data", 32'(rsp_data), 32'hD);
        checkOutput("bp_queued_count", 32'(op_count), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Chaining right after reset must see a zero accumulator.
        doReset();
        applyStimulus(3'd5, 4'hF, 4'h3, 1'b1, 4'h0, 4'h3, 2'd1, 0);

        // Reset while in EXEC drops the command silently.
        waitIdle();
        cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_a = 4'h7; cmd_b = 4'h7; cmd_chain = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("midrst_in_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_op_count", 32'(op_count), 32'd0);
        checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        m_acc = '0;
        m_cnt = 0;
        applyStimulus(3'd6, 4'h0, 4'h9, 1'b1, 4'h0, 4'h9, 2'd1, 0);

        // Counter wrap with a 2-bit counter.
        doReset();
        wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int i = 0; i < 5; i++)
            applyStimulus(3'd0, WIDTH'(i), 4'h1, 1'b0, WIDTH'(i), WIDTH'(i + 1), wrap_seq[i], 0);

        // Random traffic against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            r_sel   = 3'($urandom_range(0, 7));
            r_a     = WIDTH'($urandom);
            r_b     = WIDTH'($urandom);
            r_chain = 1'($urandom_range(0, 1));
            r_exp_a = r_chain ? m_acc : r_a;
            r_exp_d = au_func(r_exp_a, r_b, r_sel);
            applyStimulus(r_sel, r_a, r_b, r_chain, r_exp_a, r_exp_d,
                          CNT_W'((m_cnt + 1) % (1 << CNT_W)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
